// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared types and helpers for the uart_tx packet arbiter
package uart_tx_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_STREAM = 1'b1
  } arb_state_t;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned MAX_IDX_W = 3;

  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rtl/uart_tx_arbiter_rr_picker.sv - combinational round-robin picker: first request after last_i, wrapping
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               found_o
);

  logic [IW-1:0] cand;

  always_comb begin
    grant_o = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((32'(last_i) + i) % NUM_REQ);
      if (!found_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        found_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter feeding the uart_tx byte stream
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  output logic                          tx_valid_o,
  input  logic                          tx_ready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] pick;
  logic               found;
  logic               own_valid;
  logic               own_last;
  logic               xfer;
  logic [IW-1:0]      owner_idx;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i   (req_valid_i),
    .last_i  (last_q),
    .grant_o (pick),
    .found_o (found)
  );

  // Owner byte mux; grant_q is all-zero when idle, so idle outputs are zero.
  always_comb begin
    tx_data_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) tx_data_o = tx_data_o | req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign own_valid   = |(req_valid_i & grant_q);
  assign own_last    = |(req_last_i & grant_q);
  assign xfer        = own_valid & tx_ready_i;
  assign owner_idx   = IW'(onehot_to_idx(MAX_REQ'(grant_q)));
  assign tx_valid_o  = own_valid;
  assign req_ready_o = grant_q & {NUM_REQ{tx_ready_i}};
  assign grant_o     = grant_q;
  assign busy_o      = (state_q == ARB_STREAM);
  assign timeout_o   = timeout_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = ARB_STREAM;
        end
      end
      ARB_STREAM: begin
        if (xfer) begin
          cnt_d = '0;
          if (own_last) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            last_d  = owner_idx;
          end
        end else if (!own_valid && WDOG_EN) begin
          // Only source starvation counts; UART backpressure neither counts nor clears.
          if (cnt_q == CNT_LAST) begin
            state_d   = ARB_IDLE;
            grant_d   = '0;
            last_d    = owner_idx;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      last_q    <= IW'(NUM_REQ - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NR = 2;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int MAXC = 5000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [DW-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            timeout;

  int checks = 0;
  int errors = 0;
  int model_last = NR - 1;

  logic [7:0] src_b [NR][$];
  logic       src_l [NR][$];
  int         plen  [NR][$];
  logic [7:0] exp_b [$];
  int         exp_s [$];

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_data_i  (req_data),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .grant_o     (grant),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input bit v, input logic [7:0] d, input bit l);
    req_valid[s]        = v;
    req_data[s*DW +: DW] = d;
    req_last[s]         = l;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b0;
    for (int s = 0; s < NR; s++) begin
      src_b[s].delete();
      src_l[s].delete();
      plen[s].delete();
    end
    exp_b.delete();
    exp_s.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    model_last = NR - 1;
  endtask

  task automatic add_packet(input int s, input int len, input logic [7:0] first, input bit rnd);
    for (int j = 0; j < len; j++) begin
      src_b[s].push_back(rnd ? 8'($urandom) : first + 8'(j));
      src_l[s].push_back(j == len - 1);
    end
    plen[s].push_back(len);
  endtask

  // Packet-level model: every source with packets left is pending, so the
  // next packet comes from the first pending source after the previous winner.
  task automatic build_expected();
    int idx [NR];
    int ptr;
    bit found;
    ptr = model_last;
    for (int s = 0; s < NR; s++) idx[s] = 0;
    do begin
      found = 1'b0;
      for (int i = 1; i <= NR && !found; i++) begin
        int s;
        int n;
        s = (ptr + i) % NR;
        if (plen[s].size() > 0) begin
          n = plen[s].pop_front();
          for (int j = 0; j < n; j++) begin
            exp_b.push_back(src_b[s][idx[s] + j]);
            exp_s.push_back(s);
          end
          idx[s] += n;
          ptr   = s;
          found = 1'b1;
        end
      end
    end while (found);
    model_last = ptr;
  endtask

  task automatic run_traffic(input int ready_pct, input int gap_pct);
    int  cyc = 0;
    int  gapc [NR];
    bit  at_start [NR];
    bit  prev_last = 1'b0;
    bit  v;
    int  s;
    for (int k = 0; k < NR; k++) begin
      gapc[k]     = 0;
      at_start[k] = 1'b1;
    end
    while (exp_b.size() > 0 && cyc < MAXC) begin
      for (int k = 0; k < NR; k++) begin
        if (src_b[k].size() > 0) begin
          v = at_start[k] || gapc[k] >= 4 || ($urandom_range(99) >= gap_pct);
          gapc[k] = v ? 0 : gapc[k] + 1;
          set_src(k, v, src_b[k][0], src_l[k][0]);
        end else begin
          set_src(k, 1'b0, 8'h00, 1'b0);
        end
      end
      tx_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      chk("nonowner_ready", 32'(req_ready & ~grant), 0);
      chk("no_timeout", 32'(timeout), 0);
      chk("busy_vs_grant", 32'(busy), 32'(|grant));
      if (prev_last) chk("idle_gap", 32'(grant), 0);
      prev_last = 1'b0;
      if (tx_valid && tx_ready) begin
        s = grant[1] ? 1 : 0;
        chk("xfer_src", s, exp_s[0]);
        chk("xfer_byte", 32'(tx_data), 32'(exp_b[0]));
        void'(exp_b.pop_front());
        void'(exp_s.pop_front());
        if (src_b[s].size() > 0) begin
          prev_last   = src_l[s][0];
          at_start[s] = src_l[s][0];
          void'(src_b[s].pop_front());
          void'(src_l[s].pop_front());
        end
      end
      tick();
      cyc++;
    end
    chk("traffic_drained", exp_b.size(), 0);
    req_valid = '0;
    req_last  = '0;
  endtask

  initial begin
    logic [7:0] t1 [4];
    bit bad;
    t1[0] = 8'hDE; t1[1] = 8'hAD; t1[2] = 8'hBE; t1[3] = 8'hEF;

    do_reset();
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    tick();

    // Single source, 4-byte packet
    set_src(0, 1'b1, t1[0], 1'b0);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("t1_idle_grant", 32'(grant), 0);
    chk("t1_idle_valid", 32'(tx_valid), 0);
    chk("t1_idle_ready", 32'(req_ready), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_src(0, 1'b1, t1[i], i == 3);
      @(negedge clk);
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_valid", 32'(tx_valid), 1);
      chk("t1_data", 32'(tx_data), 32'(t1[i]));
      chk("t1_ready", 32'(req_ready), 32'h1);
      tick();
    end
    set_src(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t1_end_grant", 32'(grant), 0);
    chk("t1_end_busy", 32'(busy), 0);

    // Both sources with 3-byte packets, then 1-byte rotation
    do_reset();
    add_packet(0, 3, 8'h11, 1'b0);
    add_packet(1, 3, 8'h21, 1'b0);
    build_expected();
    run_traffic(100, 0);
    for (int i = 0; i < 3; i++) begin
      add_packet(0, 1, 8'h40 + 8'(i), 1'b0);
      add_packet(1, 1, 8'h50 + 8'(i), 1'b0);
    end
    build_expected();
    run_traffic(100, 0);

    // Long UART backpressure mid-packet must not trip the watchdog
    do_reset();
    tx_ready = 1'b1;
    set_src(0, 1'b1, 8'h31, 1'b0);
    tick();
    @(negedge clk);
    chk("t4_first", 32'(tx_data), 32'h31);
    tick();
    set_src(0, 1'b1, 8'h32, 1'b0);
    tx_ready = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (timeout !== 1'b0 || grant !== 2'b01 || tx_data !== 8'h32) bad = 1'b1;
      tick();
    end
    chk("t4_hold_no_timeout", 32'(bad), 0);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("t4_resume", 32'(tx_data), 32'h32);
    tick();
    set_src(0, 1'b1, 8'h33, 1'b1);
    @(negedge clk);
    chk("t4_last", 32'(tx_data), 32'h33);
    chk("t4_last_valid", 32'(tx_valid), 1);
    tick();
    set_src(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t4_end_grant", 32'(grant), 0);

    // Watchdog release after TO starved cycles, pending source 1 follows
    do_reset();
    tx_ready = 1'b1;
    set_src(0, 1'b1, 8'hA0, 1'b0);
    set_src(1, 1'b1, 8'hB0, 1'b1);
    tick();
    @(negedge clk);
    chk("t5_b0", 32'(tx_data), 32'hA0);
    tick();
    set_src(0, 1'b1, 8'hA1, 1'b0);
    @(negedge clk);
    chk("t5_b1", 32'(tx_data), 32'hA1);
    tick();
    set_src(0, 1'b0, 8'h00, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      if (timeout !== 1'b0 || grant !== 2'b01 || tx_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("t5_no_early_timeout", 32'(bad), 0);
    @(negedge clk);
    chk("t5_timeout_pulse", 32'(timeout), 1);
    chk("t5_released", 32'(grant), 0);
    tick();
    @(negedge clk);
    chk("t5_pulse_single", 32'(timeout), 0);
    chk("t5_grant_src1", 32'(grant), 32'h2);
    chk("t5_src1_byte", 32'(tx_data), 32'hB0);
    tick();
    set_src(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t5_end_grant", 32'(grant), 0);

    // Asynchronous reset during byte 2 of a 5-byte packet
    do_reset();
    tx_ready = 1'b1;
    set_src(0, 1'b1, 8'h60, 1'b0);
    tick();
    tick();
    set_src(0, 1'b1, 8'h61, 1'b0);
    tick();
    set_src(0, 1'b1, 8'h62, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(tx_valid), 0);
    chk("t6_async_grant", 32'(grant), 0);
    chk("t6_async_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    set_src(0, 1'b1, 8'h70, 1'b1);
    set_src(1, 1'b1, 8'h80, 1'b1);
    @(negedge clk);
    chk("t6_post_idle", 32'(grant), 0);
    tick();
    @(negedge clk);
    chk("t6_src0_priority", 32'(grant), 32'h1);
    chk("t6_src0_byte", 32'(tx_data), 32'h70);

    // Randomized packets with random gaps and UART backpressure
    do_reset();
    for (int p = 0; p < 8; p++) begin
      add_packet(0, $urandom_range(1, 5), 8'h00, 1'b1);
      add_packet(1, $urandom_range(1, 5), 8'h00, 1'b1);
    end
    build_expected();
    run_traffic(70, 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
